mips_fetch_stage: RTL and testbench

//  Instruction-fetch stage for the 5-stage MIPS pipeline. It owns the PC and

---
 rtl/mips_fetch_stage.sv | 113 +++++++++++
 tb/tb_mips_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_stage.sv
// Instruction fetch for the 5-stage MIPS pipeline.
// Owns the PC, reads a 1-cycle imem and buffers words for decode.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          IMEM_AW  = 10,
    parameter logic [31:0] NOP      = 32'h0000_0020
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               id_ready,
    output logic               out_valid,
    output logic [31:0]        out_ir,
    output logic [31:0]        out_pc4,
    output logic [15:0]        fetch_count
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   fifo_ir  [DEPTH];
    logic [31:0]   fifo_pc4 [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   cnt;
    logic          inflight;
    logic [31:0]   infl_pc4;

    logic          head_valid;
    logic          deq;
    logic          enq;
    logic          pop;
    logic [PW+1:0] occ;
    logic [PW+1:0] need;
    logic          unused_ok;

    assign unused_ok = ^redirect_pc[1:0];

    assign imem_addr = pc[IMEM_AW+1:2];

    // The in-flight response counts as an occupied slot; when the
    // buffer is empty it is shown to decode straight from imem.
    always_comb begin
        head_valid = (cnt != '0);
        out_valid  = head_valid | inflight;
        out_ir     = NOP;
        out_pc4    = 32'd0;
        if (head_valid) begin
            out_ir  = fifo_ir[rptr];
            out_pc4 = fifo_pc4[rptr];
        end else if (inflight) begin
            out_ir  = imem_rdata;
            out_pc4 = infl_pc4;
        end
        deq  = out_valid & id_ready;
        pop  = head_valid & deq;
        enq  = inflight & ~(~head_valid & deq);
        occ  = {1'b0, cnt} + {{(PW+1){1'b0}}, inflight};
        need = occ - {{(PW+1){1'b0}}, deq};
        imem_req = ~reset & ~redirect_valid
                 & (need < (PW+2)'(DEPTH));
    end

    // Buffer storage; contents are don't-care while unoccupied.
    always_ff @(posedge clock) begin
        if (enq && !redirect_valid) begin
            fifo_ir[wptr]  <= imem_rdata;
            fifo_pc4[wptr] <= infl_pc4;
        end
    end

    // PC, buffer pointers, in-flight tracking and delivery count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            wptr        <= '0;
            rptr        <= '0;
            cnt         <= '0;
            inflight    <= 1'b0;
            infl_pc4    <= 32'd0;
            fetch_count <= 16'd0;
        end else begin
            fetch_count <= fetch_count + {15'd0, deq};
            if (redirect_valid) begin
                pc       <= {redirect_pc[31:2], 2'b00};
                wptr     <= '0;
                rptr     <= '0;
                cnt      <= '0;
                inflight <= 1'b0;
            end else begin
                if (enq) begin
                    wptr <= wptr + PW'(1);
                end
                if (pop) begin
                    rptr <= rptr + PW'(1);
                end
                cnt <= cnt + {{PW{1'b0}}, enq}
                           - {{PW{1'b0}}, pop};
                inflight <= imem_req;
                if (imem_req) begin
                    pc       <= pc + 32'd4;
                    infl_pc4 <= pc + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed scenarios plus random
// stall/redirect traffic against an in-order stream model.
module tb_mips_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0020;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        out_valid;
    logic [31:0] out_ir;
    logic [31:0] out_pc4;
    logic [15:0] fetch_count;

    logic        w_req;
    logic [9:0]  w_addr;
    logic [31:0] w_rdata;
    logic        w_redir;
    logic [31:0] w_rpc;
    logic        w_ready;
    logic        w_valid;
    logic [31:0] w_ir;
    logic [31:0] w_pc4;
    logic [15:0] w_fc;

    logic [31:0] mem [1024];

    int passed = 0;
    int total  = 0;

    mips_fetch_stage dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_ready(id_ready), .out_valid(out_valid),
        .out_ir(out_ir), .out_pc4(out_pc4),
        .fetch_count(fetch_count)
    );

    mips_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_w (
        .clock(clock), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata),
        .redirect_valid(w_redir),
        .redirect_pc(w_rpc),
        .id_ready(w_ready), .out_valid(w_valid),
        .out_ir(w_ir), .out_pc4(w_pc4),
        .fetch_count(w_fc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // 1-cycle synchronous instruction memories
    always @(posedge clock) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
        if (w_req) w_rdata <= mem[w_addr];
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Stream model: next expected byte address and delivery count
    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    logic        p_redir, p_stall;
    logic [31:0] p_ir, p_pc4;
    int          idle;

    always @(negedge clock) begin
        if (reset) begin
            m_pc    = 32'h0;
            m_cnt   = 16'h0;
            p_redir = 1'b0;
            p_stall = 1'b0;
            idle    = 0;
        end else begin
            chk("m_fetch_count", {16'h0, fetch_count}, {16'h0, m_cnt});
            if (p_redir)
                chk("m_post_redirect", {31'h0, out_valid}, 32'h0);
            else if (p_stall) begin
                chk("m_stall_valid", {31'h0, out_valid}, 32'h1);
                chk("m_stall_ir", out_ir, p_ir);
                chk("m_stall_pc4", out_pc4, p_pc4);
            end
            if (!out_valid)
                chk("m_nop", out_ir, NOP);
            if (out_valid && id_ready) begin
                chk("m_ir", out_ir, mem[m_pc[11:2]]);
                chk("m_pc4", out_pc4, m_pc + 32'd4);
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 16'd1;
            end
            if (redirect_valid)
                m_pc = {redirect_pc[31:2], 2'b00};
            if (out_valid || redirect_valid || p_redir) idle = 0;
            else idle++;
            if (idle > 0)
                chk("m_starve", {31'h0, idle > 2}, 32'h0);
            p_redir = redirect_valid;
            p_stall = out_valid & ~id_ready & ~redirect_valid;
            p_ir    = out_ir;
            p_pc4   = out_pc4;
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        w_redir = 1'b0;
        w_rpc = 32'h0;
        w_ready = 1'b1;

        // Test 1: reset values, then A,B,C,D back to back
        cyc(2);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_ir", out_ir, NOP);
        chk("rst_pc4", out_pc4, 32'h0);
        chk("rst_fc", {16'h0, fetch_count}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        reset = 1'b0;
        #1;
        chk("t1_req", {31'h0, imem_req}, 32'h1);
        chk("t1_addr", {22'h0, imem_addr}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("t1_valid", {31'h0, out_valid}, 32'h1);
            chk("t1_ir", out_ir, mem[k]);
            chk("t1_pc4", out_pc4, 32'(4 * (k + 1)));
            if (k == 0) begin
                chk("t6_wrap_ir", w_ir, mem[1023]);
                chk("t6_wrap_pc4", w_pc4, 32'h0);
            end
            if (k == 1) begin
                chk("t6_next_ir", w_ir, mem[0]);
                chk("t6_next_pc4", w_pc4, 32'h4);
            end
        end
        cyc(1);
        chk("t1_fc", {16'h0, fetch_count}, 32'h4);

        // Test 2: stall with B at head for 5 cycles
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(2);
        id_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_ir", out_ir, mem[1]);
            chk("t2_hold_pc4", out_pc4, 32'h8);
            if (k > 0)
                chk("t2_req_off", {31'h0, imem_req}, 32'h0);
            cyc(1);
        end
        id_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk("t2_ir", out_ir, mem[k]);
            chk("t2_pc4", out_pc4, 32'(4 * (k + 1)));
            cyc(1);
        end
        chk("t2_fc", {16'h0, fetch_count}, 32'h4);

        // Test 3: redirect while B is delivered
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(2);
        chk("t3_ir_b", out_ir, mem[1]);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0043;
        cyc(1);
        redirect_valid = 1'b0;
        #1;
        chk("t3_gap", {31'h0, out_valid}, 32'h0);
        chk("t3_req_addr", {22'h0, imem_addr}, 32'd16);
        cyc(1);
        chk("t3_ir", out_ir, mem[16]);
        chk("t3_pc4", out_pc4, 32'h44);
        chk("t3_fc", {16'h0, fetch_count}, 32'h2);

        // Test 4: redirect as a response returns
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        id_ready = 1'b0;
        cyc(1);
        chk("t4_head", out_ir, mem[0]);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        cyc(1);
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        #1;
        chk("t4_gap", {31'h0, out_valid}, 32'h0);
        cyc(1);
        chk("t4_valid", {31'h0, out_valid}, 32'h1);
        chk("t4_ir", out_ir, mem[64]);
        chk("t4_pc4", out_pc4, 32'h104);
        cyc(1);
        chk("t4_ir2", out_ir, mem[65]);
        chk("t4_fc", {16'h0, fetch_count}, 32'h1);

        // Test 5: async reset with the buffer full
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(3);
        chk("t5_fc_pre", {16'h0, fetch_count}, 32'h2);
        id_ready = 1'b0;
        cyc(2);
        chk("t5_full_valid", {31'h0, out_valid}, 32'h1);
        chk("t5_full_req", {31'h0, imem_req}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_valid", {31'h0, out_valid}, 32'h0);
        chk("t5_ir", out_ir, NOP);
        chk("t5_fc", {16'h0, fetch_count}, 32'h0);
        chk("t5_req", {31'h0, imem_req}, 32'h0);
        cyc(1);
        reset = 1'b0;
        id_ready = 1'b1;
        cyc(1);
        chk("t5_restart_ir", out_ir, mem[0]);
        chk("t5_restart_pc4", out_pc4, 32'h4);

        // Random stalls and redirects against the stream model
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc = $urandom;
            cyc(1);
        end
        redirect_valid = 1'b0;
        id_ready = 1'b1;

        // Test 6: delivery counter wraps
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(65536);
        chk("t6_fc_max", {16'h0, fetch_count}, 32'hFFFF);
        cyc(1);
        chk("t6_fc_wrap", {16'h0, fetch_count}, 32'h0);
        cyc(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
